ram_port_arb: RTL
=================

Name: ram_port_arb

Overview:
- Two-host arbiter that sits directly upstream of one port of the dual-port RAM. It feeds the RAM's req/we/be/addr/wdata and consumes its 1-cycle read data.
- Lets two requesters share a single RAM port, e.g. a core data port and a DMA/debug host.
- Round-robin grant with same-cycle gnt.
- Routes each response to the host that owns it, generates write responses locally (the RAM gives no rvalid for writes), and checks addresses against the RAM range.

Parameters:
- Depth, 128, RAM depth in words; must be a power of 2.
- Width, 32, data width in bits.
- AddrOffset, 2, byte-address LSBs dropped to form the word index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- h0_req_i / h1_req_i  in  1  host request
- h0_gnt_o / h1_gnt_o  out  1  grant (combinational)
- h0_we_i / h1_we_i  in  1  write enable
- h0_be_i / h1_be_i  in  4  byte enables
- h0_addr_i / h1_addr_i  in  32  byte address
- h0_wdata_i / h1_wdata_i  in  Width  write data
- h0_rvalid_o / h1_rvalid_o  out  1  response valid
- h0_rdata_o / h1_rdata_o  out  Width  read data
- h0_err_o / h1_err_o  out  1  response error, qualified by rvalid
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  RAM write
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM byte address
- ram_wdata_o  out  Width  RAM write data
- ram_rvalid_i  in  1  RAM read valid
- ram_rdata_i  in  Width  RAM read data
- init_done_o  out  1  arbiter accepting host traffic

Behaviour:
- Reset state: all outputs 0 except as noted.
  - prio=0; response register empty.
  - init_done_o = 1 without the optional feature, 0 with it.
- Handshake: host holds req and its payload stable until gnt. A transfer occurs when req && gnt. gnt is combinational from req and prio, and is only asserted while init_done_o=1.
- Arbitration:
  - Only one host requesting: that host is granted.
  - Both requesting: host prio is granted.
  - After any grant, prio <= ~granted_index.
  - At most one grant per cycle; back-to-back grants every cycle are allowed.
- Forwarding in the grant cycle:
  - ram_* mirror the granted host's payload.
  - ram_req_o = grant && in_range.
  - in_range = (addr >> AddrOffset) < Depth, and addr[31:AddrOffset+log2(Depth)] == 0.
  - ram_* payload is driven 0 when nothing is forwarded.
- Response register, loaded on every transfer: {valid, owner, we, err=~in_range}. Cleared the cycle after it is presented unless a new transfer reloads it.
- Response timing: exactly 1 cycle after the grant, the owner gets rvalid=1.
  - Read, in range: rdata = ram_rdata_i, err=0.
  - Write, in range: rdata = 0, err=0.
  - Out of range: rdata = 0, err=1. No RAM access occurs.
  - The non-owner sees rvalid=0, rdata=0.
- ram_rvalid_i must equal (rsp_valid && ~rsp_we && ~rsp_err). Checked by assertion; not used for routing.
- Reset mid-operation: a pending response is dropped and no rvalid is emitted. Hosts must discard outstanding requests on reset.

Optional Feature:
- Macro RAM_ARB_INIT_EN.
- When defined, a 2-state FSM runs:
  - INIT (entered on reset): counter idx counts 0..Depth-1, one per cycle.
    - Each cycle drives ram_req_o=1, ram_we_o=1, ram_be_o=4'hF, ram_wdata_o=0, ram_addr_o = idx << AddrOffset.
    - Both gnt = 0 and init_done_o = 0.
    - Moves to RUN after writing idx=Depth-1, so INIT lasts Depth cycles.
  - RUN: init_done_o=1 and normal arbitration.
  - Reset during INIT restarts the FSM at idx=0.
- When not defined: no FSM or counter; init_done_o=1 from reset and hosts may be granted in the first cycle after reset.

Test Plan:
- Single host: h0 reads addr 0x10. Expected: h0_gnt_o=1 in the same cycle; ram_req_o=1, ram_addr_o=0x10, ram_we_o=0; next cycle h0_rvalid_o=1 with h0_rdata_o = RAM word 4, err=0, and h1_rvalid_o=0.
- Contention: h0 and h1 both hold read requests for 4 cycles from reset. Expected: grants go h0, h1, h0, h1, and each rvalid goes only to its owner one cycle later.
- Writes: h1 writes 0xDEADBEEF with be=4'b0011 to 0x8, then reads 0x8 after h0 has pre-written 0xFFFFFFFF there. Expected: the write response has rvalid=1, rdata=0; the read returns 0xFFFFBEEF.
- Out of range (Depth=128): h0 accesses 0x200. Expected: gnt=1, ram_req_o=0, and the next cycle gives rvalid=1, err=1, rdata=0. An immediately following in-range read responds with err=0.
- Back-to-back: h0 issues reads to 0x0, 0x4, 0x8 on consecutive cycles. Expected: three consecutive rvalid pulses with data in order.
- Init (RAM_ARB_INIT_EN, Depth=128): host requests are held from reset. Expected: 128 write cycles of zeros to addresses 0x0..0x1FC; gnt=0 and init_done_o=0 throughout. On cycle 129 init_done_o=1 and the first grant is issued. Asserting rst_i at idx=50 restarts INIT at idx=0.

Source files
------------

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin arbiter letting two hosts share one RAM port, with local write/error responses.
// Define RAM_ARB_INIT_EN to zero-fill the RAM after every reset before hosts are granted.
module ram_port_arb #(
  parameter int Depth      = 128,
  parameter int Width      = 32,
  parameter int AddrOffset = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             h0_req_i,
  output logic             h0_gnt_o,
  input  logic             h0_we_i,
  input  logic [3:0]       h0_be_i,
  input  logic [31:0]      h0_addr_i,
  input  logic [Width-1:0] h0_wdata_i,
  output logic             h0_rvalid_o,
  output logic [Width-1:0] h0_rdata_o,
  output logic             h0_err_o,
  input  logic             h1_req_i,
  output logic             h1_gnt_o,
  input  logic             h1_we_i,
  input  logic [3:0]       h1_be_i,
  input  logic [31:0]      h1_addr_i,
  input  logic [Width-1:0] h1_wdata_i,
  output logic             h1_rvalid_o,
  output logic [Width-1:0] h1_rdata_o,
  output logic             h1_err_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_be_o,
  output logic [31:0]      ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             init_done_o
);
  localparam int Aw = $clog2(Depth);
  logic init_done, prio, g0, g1, grant, in_range, fwd, we;
  logic rsp_valid, rsp_owner, rsp_we, rsp_err, rsp_data;
  logic [31:0] addr, init_addr;
`ifdef RAM_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [Aw-1:0] idx;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= INIT;
      idx   <= '0;
    end else if (state == INIT) begin
      idx <= idx + 1'b1;
      if (idx == Aw'(Depth - 1)) state <= RUN;
    end
  assign init_done = state == RUN;
  assign init_addr = 32'(idx) << AddrOffset;
`else
  assign init_done = 1'b1;
  assign init_addr = '0;
`endif
  // h1 wins only when it is alone or holds priority
  assign g1       = init_done & h1_req_i & (~h0_req_i | prio);
  assign g0       = init_done & h0_req_i & ~g1;
  assign grant    = g0 | g1;
  assign addr     = g1 ? h1_addr_i : h0_addr_i;
  assign we       = g1 ? h1_we_i : h0_we_i;
  assign in_range = addr[31:AddrOffset+Aw] == '0;
  assign fwd      = grant & in_range;
  assign h0_gnt_o = g0;
  assign h1_gnt_o = g1;
  assign init_done_o = init_done;
  assign ram_req_o   = ~init_done | fwd;
  assign ram_we_o    = ~init_done | (fwd & we);
  assign ram_be_o    = ~init_done ? 4'hF : fwd ? (g1 ? h1_be_i : h0_be_i) : 4'h0;
  assign ram_addr_o  = ~init_done ? init_addr : fwd ? addr : '0;
  assign ram_wdata_o = fwd ? (g1 ? h1_wdata_i : h0_wdata_i) : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant;
      if (grant) begin
        prio      <= ~g1;
        rsp_owner <= g1;
        rsp_we    <= we;
        rsp_err   <= ~in_range;
      end
    end
  // only in-range reads carry RAM data; writes and errors answer with zero
  assign rsp_data    = rsp_valid & ~rsp_we & ~rsp_err;
  assign h0_rvalid_o = rsp_valid & ~rsp_owner;
  assign h1_rvalid_o = rsp_valid & rsp_owner;
  assign h0_err_o    = h0_rvalid_o & rsp_err;
  assign h1_err_o    = h1_rvalid_o & rsp_err;
  assign h0_rdata_o  = (rsp_data & ~rsp_owner) ? ram_rdata_i : '0;
  assign h1_rdata_o  = (rsp_data & rsp_owner) ? ram_rdata_i : '0;
  rvalid_match: assert property (@(posedge clk_i) disable iff (rst_i) ram_rvalid_i == rsp_data);
endmodule
